// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, pattern mode encoding and colour type
// for the VGA sync generator.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 2;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    MODE_BARS   = 2'b00,
    MODE_RAMP   = 2'b01,
    MODE_ANALOG = 2'b10,
    MODE_WHITE  = 2'b11
  } mode_e;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational test-pattern colour for the pixel at h_cnt; black whenever
// the pixel is outside the visible window.
module vga_pattern_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE
) (
  input  mode_e mode,
  input  cnt_t  h_cnt,
  input  logic  visible,
  input  logic  analog_sync,
  output rgb_t  colour
);

  // Guard keeps the divisor non-zero for very narrow test builds.
  localparam int   BAR_W_I = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam cnt_t BAR_W   = cnt_t'(BAR_W_I);

  logic [2:0] bar;

  assign bar = 3'(h_cnt / BAR_W);

  always_comb begin
    colour = '0;
    if (visible) begin
      case (mode)
        MODE_BARS: begin
          colour.r = {3{bar[2]}};
          colour.g = {3{bar[1]}};
          colour.b = {3{bar[0]}};
        end
        MODE_RAMP:   colour = {3{h_cnt[9:7]}};
        MODE_ANALOG: colour = {9{analog_sync}};
        default:     colour = '1;
      endcase
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, h/v counters, frame-aligned mode
// latch, analog synchroniser and the registered sync/colour/coordinate outputs.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic [8:0] key,
  input  logic       analog_in,
  output logic [2:0] r_out,
  output logic [2:0] g_out,
  output logic [2:0] b_out,
  output logic       h_sync,
  output logic       v_sync,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       active,
  output logic       frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  generate
    if (CLK_DIV < 1 || H_TOT > 1023 || V_TOT > 1023) begin : g_bad_params
      $error("vga_sync_gen: CLK_DIV must be >= 1 and line/frame totals below 1024");
    end
  endgenerate

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam cnt_t H_LAST = cnt_t'(H_TOT - 1);
  localparam cnt_t H_VIS  = cnt_t'(H_ACTIVE);
  localparam cnt_t HS_BEG = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t V_LAST = cnt_t'(V_TOT - 1);
  localparam cnt_t V_VIS  = cnt_t'(V_ACTIVE);
  localparam cnt_t VS_BEG = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic             pix_en;
  cnt_t             h_cnt, v_cnt;
  logic             at_origin;
  mode_e            mode_q, mode_nxt;
  logic             sync_q1, analog_sync;
  logic             h_vis, v_vis, h_sync_dec, v_sync_dec;
  rgb_t             colour;
  logic             key_unused;

  assign key_unused = ^key[8:2];

  assign pix_en     = (div_cnt == DIV_LAST);
  assign at_origin  = (h_cnt == '0) && (v_cnt == '0);
  assign h_vis      = (h_cnt < H_VIS);
  assign v_vis      = (v_cnt < V_VIS);
  assign h_sync_dec = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign v_sync_dec = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  // The key is taken on the very pixel that starts a frame so (0,0) already
  // shows the new pattern, and a mid-frame change never tears the picture.
  assign mode_nxt = (pix_en && at_origin) ? mode_e'(key[1:0]) : mode_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      mode_q      <= MODE_BARS;
      sync_q1     <= 1'b0;
      analog_sync <= 1'b0;
    end else begin
      div_cnt     <= pix_en ? '0 : div_cnt + 1'b1;
      mode_q      <= mode_nxt;
      sync_q1     <= analog_in;
      analog_sync <= sync_q1;
      if (pix_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  vga_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .mode        (mode_nxt),
    .h_cnt       (h_cnt),
    .visible     (h_vis && v_vis),
    .analog_sync (analog_sync),
    .colour      (colour)
  );

  // Output stage: everything reflects the counters before this pixel's increment.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      h_sync      <= !SYNC_POL;
      v_sync      <= !SYNC_POL;
      r_out       <= '0;
      g_out       <= '0;
      b_out       <= '0;
      active      <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && at_origin;
      if (pix_en) begin
        h_sync <= h_sync_dec ? SYNC_POL : !SYNC_POL;
        v_sync <= v_sync_dec ? SYNC_POL : !SYNC_POL;
        r_out  <= colour.r;
        g_out  <= colour.g;
        b_out  <= colour.b;
        active <= h_vis && v_vis;
        pix_x  <= h_cnt;
        pix_y  <= v_cnt;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default build (CLK_DIV=2), CLK_DIV=1 build and a
// shrunken-timing build, all compared every cycle to a frame-arithmetic model.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, cdiv;
  } tim_t;

  typedef struct packed {
    logic [2:0] r, g, b;
    logic       hs, vs, act;
    logic [9:0] x, y;
  } out_t;

  typedef struct {
    int         x;
    logic [2:0] r, g, b;
    logic       act;
  } vec_t;

  localparam out_t RST_O = {3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0};

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] key_a = '0;
  logic [8:0] key_s = '0;
  logic       analog_in = 1'b0;

  always #5 clk_in = ~clk_in;

  logic [2:0] r_a, g_a, b_a, r_1, g_1, b_1, r_s, g_s, b_s;
  logic       hs_a, vs_a, act_a, fs_a, hs_1, vs_1, act_1, fs_1, hs_s, vs_s, act_s, fs_s;
  logic [9:0] x_a, y_a, x_1, y_1, x_s, y_s;

  vga_sync_gen #(.CLK_DIV(2)) u_dut_a (
    .clk_in(clk_in), .rst_n(rst_n), .key(key_a), .analog_in(analog_in),
    .r_out(r_a), .g_out(g_a), .b_out(b_a), .h_sync(hs_a), .v_sync(vs_a),
    .pix_x(x_a), .pix_y(y_a), .active(act_a), .frame_start(fs_a)
  );

  vga_sync_gen #(.CLK_DIV(1)) u_dut_1 (
    .clk_in(clk_in), .rst_n(rst_n), .key(key_a), .analog_in(analog_in),
    .r_out(r_1), .g_out(g_1), .b_out(b_1), .h_sync(hs_1), .v_sync(vs_1),
    .pix_x(x_1), .pix_y(y_1), .active(act_1), .frame_start(fs_1)
  );

  vga_sync_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(2)
  ) u_dut_s (
    .clk_in(clk_in), .rst_n(rst_n), .key(key_s), .analog_in(analog_in),
    .r_out(r_s), .g_out(g_s), .b_out(b_s), .h_sync(hs_s), .v_sync(vs_s),
    .pix_x(x_s), .pix_y(y_s), .active(act_s), .frame_start(fs_s)
  );

  out_t act_o [3];
  logic fs_o  [3];
  assign act_o[0] = {r_a, g_a, b_a, hs_a, vs_a, act_a, x_a, y_a};
  assign act_o[1] = {r_1, g_1, b_1, hs_1, vs_1, act_1, x_1, y_1};
  assign act_o[2] = {r_s, g_s, b_s, hs_s, vs_s, act_s, x_s, y_s};
  assign fs_o[0] = fs_a;
  assign fs_o[1] = fs_1;
  assign fs_o[2] = fs_s;

  // Expected outputs for pixel number k since reset, from the timing rules.
  function automatic out_t model(input tim_t t, input int k, input logic [1:0] mode, input logic an);
    out_t o;
    int ht, vt, x, y, bar;
    bit vis;
    ht = t.ha + t.hfp + t.hs + t.hbp;
    vt = t.va + t.vfp + t.vs + t.vbp;
    x = k % ht;
    y = (k / ht) % vt;
    vis = (x < t.ha) && (y < t.va);
    o.x = 10'(x);
    o.y = 10'(y);
    o.act = vis;
    o.hs = !((x >= t.ha + t.hfp) && (x < t.ha + t.hfp + t.hs));
    o.vs = !((y >= t.va + t.vfp) && (y < t.va + t.vfp + t.vs));
    o.r = 3'd0; o.g = 3'd0; o.b = 3'd0;
    if (vis) begin
      case (mode)
        2'd0: begin
          bar = x / (t.ha / 8);
          o.r = ((bar / 4) % 2 != 0) ? 3'd7 : 3'd0;
          o.g = ((bar / 2) % 2 != 0) ? 3'd7 : 3'd0;
          o.b = (bar % 2 != 0) ? 3'd7 : 3'd0;
        end
        2'd1: begin
          o.r = 3'((x / 128) % 8);
          o.g = o.r;
          o.b = o.r;
        end
        2'd2: begin
          o.r = an ? 3'd7 : 3'd0;
          o.g = o.r;
          o.b = o.r;
        end
        default: begin
          o.r = 3'd7; o.g = 3'd7; o.b = 3'd7;
        end
      endcase
    end
    return o;
  endfunction

  function automatic int frame_len(input tim_t t);
    return (t.ha + t.hfp + t.hs + t.hbp) * (t.va + t.vfp + t.vs + t.vbp);
  endfunction

  tim_t       tim    [3];
  int         m      [3];
  int         k      [3];
  logic [1:0] mode_m [3];
  out_t       exp_o  [3];
  logic       exp_fs [3];
  logic       a_h1, a_h2, an_used;
  int         cyc = 0;

  task automatic model_reset();
    a_h1 = 1'b0;
    a_h2 = 1'b0;
    for (int d = 0; d < 3; d++) begin
      m[d] = 0; k[d] = -1; mode_m[d] = 2'b00; exp_o[d] = RST_O; exp_fs[d] = 1'b0;
    end
  endtask

  initial begin
    tim[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
    tim[1] = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    tim[2] = '{16, 2, 3, 3, 6, 1, 2, 1, 2};
    model_reset();
    forever begin
      @(posedge clk_in or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        // Colour uses the comparator value seen two clock edges earlier.
        an_used = a_h2;
        a_h2 = a_h1;
        a_h1 = analog_in;
        for (int d = 0; d < 3; d++) begin
          exp_fs[d] = 1'b0;
          m[d]++;
          if (m[d] % tim[d].cdiv == 0) begin
            k[d]++;
            if (k[d] % frame_len(tim[d]) == 0) begin
              mode_m[d] = (d == 2) ? key_s[1:0] : key_a[1:0];
              exp_fs[d] = 1'b1;
            end
            exp_o[d] = model(tim[d], k[d], mode_m[d], an_used);
          end
        end
      end
    end
  end

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  int total = 0;
  int bad = 0;
  int nshow = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  // Advance to the next falling edge and compare every DUT against the model.
  task automatic tick();
    @(negedge clk_in);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (act_o[d] !== exp_o[d] || fs_o[d] !== exp_fs[d]) begin
        bad++;
        if (nshow < 10) begin
          nshow++;
          $display("FAIL model_dut%0d t=%0t got=%h fs=%b want=%h fs=%b",
                   d, $time, act_o[d], fs_o[d], exp_o[d], exp_fs[d]);
        end
      end
    end
  endtask

  task automatic wait_a(input int x, input int y, input string nm);
    int n = 0;
    while (!(x_a == 10'(x) && (y < 0 || y_a == 10'(y))) && n < 4000) begin
      tick();
      n++;
    end
    chk(nm, 32'(n < 4000), 32'd1);
  endtask

  task automatic wait_s(input int x, input int y, input string nm);
    int n = 0;
    while (!(x_s == 10'(x) && y_s == 10'(y)) && n < 2000) begin
      tick();
      n++;
    end
    chk(nm, 32'(n < 2000), 32'd1);
  endtask

  task automatic wait_bit(ref logic sig, input logic val, input int lim, input string nm);
    int n = 0;
    while (sig !== val && n < lim) begin
      tick();
      n++;
    end
    chk(nm, 32'(n < lim), 32'd1);
  endtask

  task automatic run_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 7) == 0) analog_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) key_s = 9'($urandom_range(0, 511));
      tick();
    end
  endtask

  initial begin
    vec_t tbl [12];
    int   n, na, n1, t0, t1, t2, t3, px;
    logic seen_a, seen_1;

    tbl[0]  = '{0,   3'd0, 3'd0, 3'd0, 1'b1};
    tbl[1]  = '{79,  3'd0, 3'd0, 3'd0, 1'b1};
    tbl[2]  = '{80,  3'd0, 3'd0, 3'd7, 1'b1};
    tbl[3]  = '{159, 3'd0, 3'd0, 3'd7, 1'b1};
    tbl[4]  = '{160, 3'd0, 3'd7, 3'd0, 1'b1};
    tbl[5]  = '{300, 3'd0, 3'd7, 3'd7, 1'b1};
    tbl[6]  = '{479, 3'd7, 3'd0, 3'd7, 1'b1};
    tbl[7]  = '{559, 3'd7, 3'd7, 3'd0, 1'b1};
    tbl[8]  = '{560, 3'd7, 3'd7, 3'd7, 1'b1};
    tbl[9]  = '{639, 3'd7, 3'd7, 3'd7, 1'b1};
    tbl[10] = '{640, 3'd0, 3'd0, 3'd0, 1'b0};
    tbl[11] = '{799, 3'd0, 3'd0, 3'd0, 1'b0};

    // Power-on reset state.
    repeat (3) tick();
    chk("rst_hsync", 32'(hs_a), 32'd1);
    chk("rst_vsync", 32'(vs_a), 32'd1);
    chk("rst_rgb", 32'({r_a, g_a, b_a}), 32'd0);
    chk("rst_pix", 32'({x_a, y_a}), 32'd0);
    chk("rst_active_fs", 32'({act_a, fs_a}), 32'd0);
    rst_n = 1'b1;

    // Colour bars along line 0 of the default build.
    wait_bit(fs_a, 1'b1, 20, "wait_first_fs");
    for (int i = 0; i < 12; i++) begin
      wait_a(tbl[i].x, 0, $sformatf("wait_bars_x%0d", tbl[i].x));
      chk($sformatf("bars_rgb_x%0d", tbl[i].x), 32'({r_a, g_a, b_a}),
          32'({tbl[i].r, tbl[i].g, tbl[i].b}));
      chk($sformatf("bars_active_x%0d", tbl[i].x), 32'(act_a), 32'(tbl[i].act));
    end

    // Horizontal sync placement and width, CLK_DIV=2.
    wait_a(0, 1, "wait_line1");
    t0 = cyc;
    wait_bit(hs_a, 1'b0, 2000, "wait_hs_fall");
    t1 = cyc;
    wait_bit(hs_a, 1'b1, 2000, "wait_hs_rise");
    t2 = cyc;
    wait_bit(hs_a, 1'b0, 2000, "wait_hs_fall2");
    t3 = cyc;
    chk("hsync_fall_after_x0", 32'(t1 - t0), 32'd1312);
    chk("hsync_low_cycles", 32'(t2 - t1), 32'd192);
    chk("hsync_period", 32'(t3 - t1), 32'd1600);

    // CLK_DIV=1 build.
    wait_bit(hs_1, 1'b1, 1000, "wait_hs1_high");
    wait_bit(hs_1, 1'b0, 1000, "wait_hs1_fall");
    t1 = cyc;
    wait_bit(hs_1, 1'b1, 1000, "wait_hs1_rise");
    wait_bit(hs_1, 1'b0, 1000, "wait_hs1_fall2");
    chk("div1_hsync_period", 32'(cyc - t1), 32'd800);
    n = 0;
    while (x_1 != 10'd100 && n < 1000) begin
      tick();
      n++;
    end
    chk("wait_div1_x100", 32'(n < 1000), 32'd1);
    for (int i = 0; i < 8; i++) begin
      px = int'(x_1);
      tick();
      chk("div1_pix_step", 32'(x_1), 32'(px + 1));
    end

    // Vertical sync on the shrunken build: 2 lines of 24 pixels, 10-line frame.
    wait_bit(vs_s, 1'b1, 1000, "wait_vs_high");
    wait_bit(vs_s, 1'b0, 1000, "wait_vs_fall");
    t1 = cyc;
    wait_bit(vs_s, 1'b1, 1000, "wait_vs_rise");
    t2 = cyc;
    wait_bit(vs_s, 1'b0, 1000, "wait_vs_fall2");
    chk("vsync_low_cycles", 32'(t2 - t1), 32'd96);
    chk("vsync_period", 32'(cyc - t1), 32'd480);

    // Mode latch: key change mid-frame only takes effect at the next frame.
    key_s = 9'h000;
    tick();
    wait_bit(fs_s, 1'b0, 1000, "wait_fs_low");
    wait_bit(fs_s, 1'b1, 1000, "wait_bars_frame");
    wait_s(0, 3, "wait_s_line3");
    key_s = 9'h1FF;
    wait_s(2, 5, "wait_s_x2y5");
    chk("latch_still_bars", 32'({r_s, g_s, b_s}), 32'({3'd0, 3'd0, 3'd7}));
    wait_bit(fs_s, 1'b1, 1000, "wait_white_frame");
    chk("latch_white_rgb", 32'({r_s, g_s, b_s}), 32'h1FF);
    chk("latch_white_pix", 32'({x_s, y_s}), 32'd0);

    // Asynchronous reset mid-line, then release with analog mode selected.
    wait_a(300, -1, "wait_x300");
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_syncs", 32'({hs_a, vs_a}), 32'd3);
    chk("midrst_rgb", 32'({r_a, g_a, b_a}), 32'd0);
    chk("midrst_pix", 32'({x_a, y_a}), 32'd0);
    chk("midrst_active_fs", 32'({act_a, fs_a}), 32'd0);
    key_a = 9'h002;
    analog_in = 1'b0;
    tick();
    rst_n = 1'b1;
    n = 0; na = 0; n1 = 0; seen_a = 1'b0; seen_1 = 1'b0;
    while (!(seen_a && seen_1) && n < 10) begin
      tick();
      n++;
      if (fs_a && !seen_a) begin seen_a = 1'b1; na = n; end
      if (fs_1 && !seen_1) begin seen_1 = 1'b1; n1 = n; end
    end
    chk("fs_latency_div2", 32'(na), 32'd2);
    chk("fs_latency_div1", 32'(n1), 32'd1);

    // Analog mode latency and blanking.
    wait_a(10, 0, "wait_analog_x10");
    analog_in = 1'b1;
    n = 0;
    while (r_a != 3'd7 && n < 10) begin tick(); n++; end
    chk("analog_rise_latency_ok", 32'(n >= 2 && n <= 4), 32'd1);
    chk("analog_rise_rgb", 32'({r_a, g_a, b_a}), 32'h1FF);
    analog_in = 1'b0;
    n = 0;
    while (r_a != 3'd0 && n < 10) begin tick(); n++; end
    chk("analog_fall_latency_ok", 32'(n >= 2 && n <= 4), 32'd1);
    chk("analog_fall_rgb", 32'({r_a, g_a, b_a}), 32'd0);
    analog_in = 1'b1;
    wait_a(700, 0, "wait_analog_x700");
    chk("analog_blanking_rgb", 32'({r_a, g_a, b_a}), 32'd0);

    // Random keys and comparator activity, checked against the model.
    run_random(20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
